// File: rtl/ifid_stall_ctrl.sv
// IF/ID pipeline register and PC enable: turns stall, flush and memory-freeze
// into register holds, ID/EX bubbles and wrong-path squashes; watches for runaway stalls.
module ifid_stall_ctrl #(
  parameter int unsigned        INSTR_W    = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR  = INSTR_W'(16'h0800),
  parameter int unsigned        SQUASH_CYC = 2,
  parameter int unsigned        STALL_MAX  = 15,
  parameter int unsigned        CNT_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] pcInc_in,
  input  logic               fetch_valid,
  input  logic               stall_req,
  input  logic               flush,
  input  logic               freeze,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pcInc_out,
  output logic               valid_out,
  output logic               pc_en,
  output logic               bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic               stall_timeout
);

  localparam int unsigned      SQ_W      = 2;
  localparam logic [SQ_W-1:0]  SQ_LAST   = SQ_W'(SQUASH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] CNT_PRE_T = CNT_W'(STALL_MAX - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t          state;
  logic [SQ_W-1:0] sq_cnt;

  // PC enable and bubble depend only on state and control inputs, never on instr_in
  always_comb begin
    pc_en  = 1'b0;
    bubble = 1'b0;
    if (freeze) begin
      if (flush || state == SQUASH) begin
        pc_en  = 1'b1;
        bubble = 1'b1;
      end else if (stall_req) begin
        pc_en  = 1'b0;
        bubble = 1'b1;
      end else begin
        pc_en  = 1'b1;
        bubble = 1'b0;
      end
    end
  end

  // A stalled state with stall_req dropped behaves as RUN: the held instruction
  // goes to decode this cycle and the next fetch is captured at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      sq_cnt        <= '0;
      instr_out     <= NOP_INSTR;
      pcInc_out     <= '0;
      valid_out     <= 1'b0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else if (freeze) begin
      if (flush) begin
        state     <= SQUASH;
        sq_cnt    <= '0;
        instr_out <= NOP_INSTR;
        pcInc_out <= pcInc_in;
        valid_out <= 1'b0;
        stall_cnt <= '0;
      end else if (state == SQUASH) begin
        instr_out <= NOP_INSTR;
        pcInc_out <= pcInc_in;
        valid_out <= 1'b0;
        stall_cnt <= '0;
        if (sq_cnt == SQ_LAST) begin
          state  <= RUN;
          sq_cnt <= '0;
        end else begin
          sq_cnt <= sq_cnt + SQ_W'(1);
        end
      end else if (stall_req) begin
        state <= STALL;
        if (stall_cnt != CNT_SAT) stall_cnt <= stall_cnt + CNT_W'(1);
        if (stall_cnt == CNT_PRE_T) stall_timeout <= 1'b1;
      end else begin
        state     <= RUN;
        instr_out <= fetch_valid ? instr_in : NOP_INSTR;
        pcInc_out <= pcInc_in;
        valid_out <= fetch_valid;
        stall_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// Directed table-driven bench for ifid_stall_ctrl plus hand sequences for
// long stalls and reset during stall/squash.
module tb_ifid_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in, pcInc_in;
  logic        fetch_valid, stall_req, flush, freeze;
  logic [15:0] instr_out, pcInc_out;
  logic        valid_out, pc_en, bubble, stall_timeout;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  ifid_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .pcInc_in     (pcInc_in),
    .fetch_valid  (fetch_valid),
    .stall_req    (stall_req),
    .flush        (flush),
    .freeze       (freeze),
    .instr_out    (instr_out),
    .pcInc_out    (pcInc_out),
    .valid_out    (valid_out),
    .pc_en        (pc_en),
    .bubble       (bubble),
    .stall_cnt    (stall_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        fv, st, fl, fz;
    logic        e_pe, e_bb;
    logic [15:0] e_instr, e_pc;
    logic        e_valid;
    logic [3:0]  e_cnt;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] instr, input logic [15:0] pc,
                              input logic fv, input logic st, input logic fl, input logic fz,
                              input logic e_pe, input logic e_bb,
                              input logic [15:0] e_instr, input logic [15:0] e_pc,
                              input logic e_valid, input logic [3:0] e_cnt, input logic e_to);
    vec_t v;
    v.instr = instr; v.pc = pc; v.fv = fv; v.st = st; v.fl = fl; v.fz = fz;
    v.e_pe = e_pe; v.e_bb = e_bb; v.e_instr = e_instr; v.e_pc = e_pc;
    v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_to = e_to;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] p, input logic fv,
                       input logic st, input logic fl, input logic fz);
    @(negedge clk);
    instr_in = i; pcInc_in = p; fetch_valid = fv;
    stall_req = st; flush = fl; freeze = fz;
    #1;
  endtask

  task automatic chk_comb(input string tag, input logic pe, input logic bb);
    chk({tag, ".pc_en"}, 32'(pc_en), 32'(pe));
    chk({tag, ".bubble"}, 32'(bubble), 32'(bb));
  endtask

  task automatic chk_regs(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                          input logic ev, input logic [3:0] ec, input logic et);
    @(posedge clk);
    #1;
    chk({tag, ".instr_out"}, 32'(instr_out), 32'(ei));
    chk({tag, ".pcInc_out"}, 32'(pcInc_out), 32'(ep));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(ev));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(ec));
    chk({tag, ".stall_timeout"}, 32'(stall_timeout), 32'(et));
  endtask

  initial begin
    rst = 1'b1; instr_in = '0; pcInc_in = '0; fetch_valid = 1'b0;
    stall_req = 1'b0; flush = 1'b0; freeze = 1'b1;

    // inputs        instr     pc       fv st fl fz  pe bb  instr_out pcInc    v  cnt to
    add(16'hA123, 16'h0002, 1, 0, 0, 1,  1, 0, 16'hA123, 16'h0002, 1, 0,  0); // advance
    add(16'hB456, 16'h0004, 1, 1, 0, 1,  0, 1, 16'hA123, 16'h0002, 1, 1,  0); // stall 1
    add(16'hB456, 16'h0004, 1, 1, 0, 1,  0, 1, 16'hA123, 16'h0002, 1, 2,  0);
    add(16'hB456, 16'h0004, 1, 1, 0, 1,  0, 1, 16'hA123, 16'h0002, 1, 3,  0);
    add(16'hB456, 16'h0004, 1, 0, 0, 1,  1, 0, 16'hB456, 16'h0004, 1, 0,  0); // release
    add(16'hC789, 16'h0006, 1, 0, 0, 1,  1, 0, 16'hC789, 16'h0006, 1, 0,  0);
    add(16'h1111, 16'h0008, 0, 0, 0, 1,  1, 0, 16'h0800, 16'h0008, 0, 0,  0); // invalid fetch
    add(16'h2222, 16'h000A, 1, 1, 0, 1,  0, 1, 16'h0800, 16'h0008, 0, 1,  0); // stall on bubble
    add(16'h3333, 16'h000C, 1, 1, 1, 1,  1, 1, 16'h0800, 16'h000C, 0, 0,  0); // flush+stall
    add(16'h4444, 16'h000E, 1, 1, 0, 1,  1, 1, 16'h0800, 16'h000E, 0, 0,  0); // squash 1
    add(16'h5555, 16'h0010, 1, 0, 0, 1,  1, 1, 16'h0800, 16'h0010, 0, 0,  0); // squash 2
    add(16'h6666, 16'h0012, 1, 0, 0, 1,  1, 0, 16'h6666, 16'h0012, 1, 0,  0); // run again
    add(16'h7777, 16'h0014, 1, 1, 0, 1,  0, 1, 16'h6666, 16'h0012, 1, 1,  0);
    add(16'h7777, 16'h0014, 1, 1, 0, 1,  0, 1, 16'h6666, 16'h0012, 1, 2,  0);
    add(16'h7777, 16'h0014, 1, 1, 0, 0,  0, 0, 16'h6666, 16'h0012, 1, 2,  0); // freeze x4
    add(16'h7777, 16'h0014, 1, 1, 0, 0,  0, 0, 16'h6666, 16'h0012, 1, 2,  0);
    add(16'h7777, 16'h0014, 1, 1, 0, 0,  0, 0, 16'h6666, 16'h0012, 1, 2,  0);
    add(16'h7777, 16'h0014, 1, 1, 0, 0,  0, 0, 16'h6666, 16'h0012, 1, 2,  0);
    add(16'h7777, 16'h0014, 1, 1, 0, 1,  0, 1, 16'h6666, 16'h0012, 1, 3,  0); // resumes
    add(16'h8888, 16'h0016, 1, 0, 1, 1,  1, 1, 16'h0800, 16'h0016, 0, 0,  0); // flush in stall
    add(16'h9999, 16'h0018, 1, 0, 1, 1,  1, 1, 16'h0800, 16'h0018, 0, 0,  0); // re-flush
    add(16'h9999, 16'h001A, 1, 0, 0, 1,  1, 1, 16'h0800, 16'h001A, 0, 0,  0);
    add(16'h9999, 16'h001C, 1, 0, 0, 1,  1, 1, 16'h0800, 16'h001C, 0, 0,  0);
    add(16'hABCD, 16'h001E, 1, 0, 0, 1,  1, 0, 16'hABCD, 16'h001E, 1, 0,  0);
    add(16'hEEEE, 16'h0020, 1, 0, 1, 0,  0, 0, 16'hABCD, 16'h001E, 1, 0,  0); // flush frozen
    add(16'h1234, 16'h0022, 1, 0, 0, 1,  1, 0, 16'h1234, 16'h0022, 1, 0,  0);

    // reset, checked while rst is still asserted
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.instr_out", 32'(instr_out), 32'h0800);
    chk("reset.pcInc_out", 32'(pcInc_out), 32'h0);
    chk("reset.valid_out", 32'(valid_out), 32'h0);
    chk("reset.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("reset.stall_timeout", 32'(stall_timeout), 32'h0);
    chk("reset.pc_en", 32'(pc_en), 32'h1);
    chk("reset.bubble", 32'(bubble), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].instr, vecs[i].pc, vecs[i].fv, vecs[i].st, vecs[i].fl, vecs[i].fz);
      chk_comb(tag, vecs[i].e_pe, vecs[i].e_bb);
      chk_regs(tag, vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_cnt, vecs[i].e_to);
    end

    // long stall: count saturates at 15, timeout sets on the 15th stall edge
    for (int k = 1; k <= 20; k++) begin
      string tag;
      tag = $sformatf("long%0d", k);
      drive(16'h5A5A, 16'h0030, 1, 1, 0, 1);
      chk_comb(tag, 1'b0, 1'b1);
      chk_regs(tag, 16'h1234, 16'h0022, 1'b1, (k < 15) ? 4'(k) : 4'd15, (k >= 15));
    end
    drive(16'h4321, 16'h0040, 1, 0, 0, 1);
    chk_comb("long_rel", 1'b1, 1'b0);
    chk_regs("long_rel", 16'h4321, 16'h0040, 1'b1, 4'd0, 1'b1);
    drive(16'h4322, 16'h0042, 1, 0, 0, 1);
    chk_regs("long_after", 16'h4322, 16'h0042, 1'b1, 4'd0, 1'b1);

    // reset in the middle of a stall
    drive(16'h0101, 16'h0044, 1, 1, 0, 1);
    chk_regs("rst_stall_a", 16'h4322, 16'h0042, 1'b1, 4'd1, 1'b1);
    drive(16'h0101, 16'h0044, 1, 1, 0, 1);
    rst = 1'b1;
    chk_regs("rst_stall", 16'h0800, 16'h0000, 1'b0, 4'd0, 1'b0);
    drive(16'h0202, 16'h0046, 1, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk_comb("rst_stall_post", 1'b1, 1'b0);
    chk_regs("rst_stall_post", 16'h0202, 16'h0046, 1'b1, 4'd0, 1'b0);

    // reset in the middle of a squash
    drive(16'h0303, 16'h0048, 1, 0, 1, 1);
    chk_regs("rst_sq_flush", 16'h0800, 16'h0048, 1'b0, 4'd0, 1'b0);
    drive(16'h0404, 16'h004A, 1, 0, 0, 1);
    rst = 1'b1;
    chk_regs("rst_squash", 16'h0800, 16'h0000, 1'b0, 4'd0, 1'b0);
    drive(16'h0505, 16'h004C, 1, 0, 0, 1);
    rst = 1'b0;
    #1;
    chk_comb("rst_sq_post", 1'b1, 1'b0);
    chk_regs("rst_sq_post", 16'h0505, 16'h004C, 1'b1, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
